// File: rtl/fifo_salida_pkg.sv
// Shared sizing defaults and helper types for the output-lane FIFO and its neighbours.
// Stateless; nothing here is clocked.
// Backpressure semantics live in fifo_salida; this package only fixes widths and encodings.
package fifo_salida_pkg;

    localparam int DATA_W_DEF = 6;
    localparam int ADDR_W_DEF = 3;

    // Number of entries addressed by a pointer of the given width.
    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    // What the occupancy counter does on a given edge.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

endpackage

// File: rtl/fifo_salida_mem.sv
// Storage array for the output-lane FIFO: synchronous write, asynchronous read, no reset.
// Write lands on the clock edge; read data follows rd_addr combinationally.
// No flow control; the caller only asserts we when the slot is free.
module memoria_fifo
    import fifo_salida_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_salida.sv
// Output-lane FIFO between the 4-way arbiter and the lane consumer, with run-time thresholds.
// Read latency 1 cycle (data_out/valid_out registered); flags follow the registered count.
// almost_full backpressures the arbiter; pushes at full without a pop are dropped and flag error.
module fifo_salida
    import fifo_salida_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic [ADDR_W:0]   umbral_alto,
    input  logic [ADDR_W:0]   umbral_bajo,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              full,
    output logic              empty,
    output logic              error
);

    localparam int               DEPTH   = fifo_depth(ADDR_W);
    localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]  CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] rd_data;

    logic    pop_ok;
    logic    push_ok;
    logic    overflow;
    logic    underflow;
    cnt_op_e cnt_op;

    // Pop is judged first: a push at full is only legal if a slot frees the same cycle.
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign overflow  = push && full && !pop_ok;
    assign underflow = pop && empty;

    always_comb begin
        cnt_op = CNT_HOLD;
        if (push_ok && !pop_ok) begin
            cnt_op = CNT_INC;
        end else if (pop_ok && !push_ok) begin
            cnt_op = CNT_DEC;
        end
    end

    memoria_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we      (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count <= '0;
        end else begin
            case (cnt_op)
                CNT_INC: count <= count + CNT_ONE;
                CNT_DEC: count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // data_out keeps its last word when nothing is popped; valid_out marks fresh data.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            if (pop_ok) begin
                data_out <= rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            error <= 1'b0;
        end else if (overflow || underflow) begin
            error <= 1'b1;
        end
    end

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= umbral_alto);
    assign almost_empty = (count <= umbral_bajo);

endmodule

// File: tb/tb_fifo_salida.sv
// Directed self-checking bench for fifo_salida: reset, fill, drain, full push/pop, wrap, async reset.
module tb_fifo_salida;

    localparam int DW = 6;
    localparam int AW = 3;

    logic          clk;
    logic          reset_L;
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [AW:0]   umbral_alto;
    logic [AW:0]   umbral_bajo;
    logic          almost_full;
    logic          almost_empty;
    logic          full;
    logic          empty;
    logic          error;

    int total;
    int bad;

    fifo_salida #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .full         (full),
        .empty        (empty),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs for one clock edge and return 1ns after it.
    task automatic step(input logic p, input logic [DW-1:0] d, input logic q);
        push    = p;
        data_in = d;
        pop     = q;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_reset();
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        reset_L = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        umbral_alto = 4'd6;
        umbral_bajo = 4'd1;
        do_reset();
        step(1'b0, '0, 1'b0);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_almost_empty got=%b want=1", almost_empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_almost_full got=%b want=0", almost_full); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", error); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_out); end
        total++; if (data_out !== 6'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data_out); end
    endtask

    task automatic test_fill();
        logic [DW-1:0] d;
        for (int i = 1; i <= 8; i++) begin
            d = DW'(i);
            step(1'b1, d, 1'b0);
            total++; if (almost_empty !== (i <= 1)) begin bad++; $display("FAIL fill_almost_empty n=%0d got=%b want=%b", i, almost_empty, (i <= 1)); end
            total++; if (almost_full !== (i >= 6)) begin bad++; $display("FAIL fill_almost_full n=%0d got=%b want=%b", i, almost_full, (i >= 6)); end
            total++; if (full !== (i == 8)) begin bad++; $display("FAIL fill_full n=%0d got=%b want=%b", i, full, (i == 8)); end
            total++; if (empty !== 1'b0) begin bad++; $display("FAIL fill_empty n=%0d got=%b want=0", i, empty); end
            total++; if (error !== 1'b0) begin bad++; $display("FAIL fill_error n=%0d got=%b want=0", i, error); end
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, '0, 1'b1);
            total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL drain_valid n=%0d got=%b want=1", i, valid_out); end
            total++; if (data_out !== DW'(i)) begin bad++; $display("FAIL drain_data n=%0d got=%h want=%h", i, data_out, DW'(i)); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", empty); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL drain_error_before got=%b want=0", error); end
        step(1'b0, '0, 1'b1);
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL underflow_valid got=%b want=0", valid_out); end
        total++; if (error !== 1'b1) begin bad++; $display("FAIL underflow_error got=%b want=1", error); end
        total++; if (data_out !== 6'h08) begin bad++; $display("FAIL underflow_data_hold got=%h want=08", data_out); end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] d;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            d = DW'(8'h31 + i);
            step(1'b1, d, 1'b0);
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fpp_full_pre got=%b want=1", full); end
        step(1'b1, 6'h2A, 1'b1);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fpp_full_after got=%b want=1", full); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL fpp_error got=%b want=0", error); end
        total++; if (data_out !== 6'h31 || valid_out !== 1'b1) begin bad++; $display("FAIL fpp_first got=%h/%b want=31/1", data_out, valid_out); end
        step(1'b1, 6'h3F, 1'b0);
        total++; if (error !== 1'b1) begin bad++; $display("FAIL overflow_error got=%b want=1", error); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL overflow_full got=%b want=1", full); end
        for (int i = 0; i < 7; i++) exp_q.push_back(DW'(8'h32 + i));
        exp_q.push_back(6'h2A);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b1);
            total++; if (data_out !== exp_q[i] || valid_out !== 1'b1) begin bad++; $display("FAIL fpp_drain n=%0d got=%h/%b want=%h/1", i, data_out, valid_out, exp_q[i]); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL fpp_empty got=%b want=1", empty); end
        step(1'b0, '0, 1'b1);
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL overflow_dropped got=%b want=0", valid_out); end
    endtask

    task automatic test_empty_push_pop();
        do_reset();
        step(1'b1, 6'h22, 1'b1);
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL epp_no_bypass got=%b want=0", valid_out); end
        total++; if (data_out !== 6'h00) begin bad++; $display("FAIL epp_data got=%h want=00", data_out); end
        total++; if (error !== 1'b1) begin bad++; $display("FAIL epp_error got=%b want=1", error); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL epp_empty got=%b want=0", empty); end
        step(1'b0, '0, 1'b1);
        total++; if (data_out !== 6'h22 || valid_out !== 1'b1) begin bad++; $display("FAIL epp_read got=%h/%b want=22/1", data_out, valid_out); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] sb [$];
        logic [DW-1:0] d;
        logic [DW-1:0] exp;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d = DW'(8'h10 + i);
            sb.push_back(d);
            step(1'b1, d, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            d = DW'(8'h13 + i);
            exp = sb.pop_front();
            sb.push_back(d);
            step(1'b1, d, 1'b1);
            total++; if (data_out !== exp || valid_out !== 1'b1) begin bad++; $display("FAIL wrap_data n=%0d got=%h/%b want=%h/1", i, data_out, valid_out, exp); end
        end
        total++; if (almost_empty !== 1'b0 || empty !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL wrap_flags got=%b%b%b want=000", almost_empty, empty, full); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL wrap_error got=%b want=0", error); end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] d;
        do_reset();
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            d = DW'(8'h05 + i);
            step(1'b1, d, 1'b0);
        end
        step(1'b0, '0, 1'b1);
        total++; if (error !== 1'b1 || valid_out !== 1'b1 || data_out !== 6'h05) begin bad++; $display("FAIL ar_pre got=%b/%b/%h want=1/1/05", error, valid_out, data_out); end
        #2;
        reset_L = 1'b0;
        #1;
        total++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin bad++; $display("FAIL ar_empty got=%b%b want=11", empty, almost_empty); end
        total++; if (full !== 1'b0 || almost_full !== 1'b0) begin bad++; $display("FAIL ar_full got=%b%b want=00", full, almost_full); end
        total++; if (error !== 1'b0 || valid_out !== 1'b0 || data_out !== 6'h00) begin bad++; $display("FAIL ar_outs got=%b/%b/%h want=0/0/00", error, valid_out, data_out); end
        repeat (2) @(posedge clk);
        #1;
        reset_L = 1'b1;
        step(1'b1, 6'h3C, 1'b0);
        step(1'b1, 6'h15, 1'b1);
        total++; if (data_out !== 6'h3C || valid_out !== 1'b1) begin bad++; $display("FAIL ar_first got=%h/%b want=3c/1", data_out, valid_out); end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset_L     = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        data_in     = '0;
        umbral_alto = 4'd6;
        umbral_bajo = 4'd1;
        test_reset();
        test_fill();
        test_drain();
        test_full_push_pop();
        test_empty_push_pop();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
